// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the icache/dcache memory-port arbiter.
// State encodings, transfer size and requester identities.
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_e;

    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/cache_mem_arbiter_arb_rr2.sv
// Combinational two-way grant between icache and dcache.
// The last-owner pointer lives in the parent.
module arb_rr2
    import cache_mem_arbiter_pkg::*;
#(
    parameter int FAIR = 1
) (
    input  logic req_i,
    input  logic req_d,
    input  logic last_owner,
    output logic grant,
    output logic owner
);

    always_comb begin
        grant = req_i | req_d;
        owner = OWNER_I;
        if (req_i && req_d) begin
            // Tie: alternate when fair, otherwise data side wins
            if (FAIR != 0) begin
                owner = ~last_owner;
            end else begin
                owner = OWNER_D;
            end
        end else if (req_d) begin
            owner = OWNER_D;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one SRAM-like memory port between icache and dcache.
// One transaction in flight; each grant answered by a single dok pulse.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int FAIR   = 1
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_cache_req,
    input  logic [ADDR_W-1:0] inst_cache_addr,
    output logic [DATA_W-1:0] inst_cache_rdata,
    output logic              inst_cache_dok,

    input  logic              data_cache_req,
    input  logic              data_cache_wr,
    input  logic [ADDR_W-1:0] data_cache_addr,
    input  logic [DATA_W-1:0] data_cache_wdata,
    output logic [DATA_W-1:0] data_cache_rdata,
    output logic              data_cache_dok,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e state;
    logic       owner;
    logic       last_owner;
    logic       grant;
    logic       grant_owner;
    logic       done;

    assign mem_size = MEM_SIZE_WORD;

    arb_rr2 #(
        .FAIR(FAIR)
    ) u_rr (
        .req_i      (inst_cache_req),
        .req_d      (data_cache_req),
        .last_owner (last_owner),
        .grant      (grant),
        .owner      (grant_owner)
    );

    // Memory has finished the in-flight transfer on this edge
    assign done = ((state == ARB_ADDR) && mem_addr_ok && mem_data_ok)
               || ((state == ARB_DATA) && mem_data_ok);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= ARB_IDLE;
            owner            <= OWNER_I;
            last_owner       <= OWNER_D;
            mem_req          <= 1'b0;
            mem_wr           <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            inst_cache_rdata <= '0;
            data_cache_rdata <= '0;
            inst_cache_dok   <= 1'b0;
            data_cache_dok   <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant) begin
                        owner      <= grant_owner;
                        last_owner <= grant_owner;
                        mem_req    <= 1'b1;
                        state      <= ARB_ADDR;
                        if (grant_owner == OWNER_D) begin
                            mem_addr  <= data_cache_addr;
                            mem_wr    <= data_cache_wr;
                            mem_wdata <= data_cache_wdata;
                        end else begin
                            mem_addr  <= inst_cache_addr;
                            mem_wr    <= 1'b0;
                        end
                    end
                end
                ARB_ADDR: begin
                    if (mem_addr_ok) begin
                        mem_req <= 1'b0;
                        state   <= mem_data_ok ? ARB_RESP : ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    if (mem_data_ok) begin
                        state <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    inst_cache_dok <= 1'b0;
                    data_cache_dok <= 1'b0;
                    state          <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase

            if (done) begin
                if (owner == OWNER_D) begin
                    data_cache_dok <= 1'b1;
                    if (!mem_wr) begin
                        data_cache_rdata <= mem_rdata;
                    end
                end else begin
                    inst_cache_dok <= 1'b1;
                    if (!mem_wr) begin
                        inst_cache_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

endmodule
